vector_macn: RTL and testbench
==============================

# vector_macn

Multi-channel successor to the single-result vector multiply-accumulate used in the conv/FC compute arrays. Each input beat carries CPF activations that are shared across NCH output channels, each channel having its own CPF weights. Every channel accumulates over a variable-length vector ended by `in_last`, then has its per-channel bias added and is requantised, saturated and optionally ReLU'd. The NCH results are serialised one per cycle on a valid/ready output port with backpressure. The block sits between the weight/activation fetch logic and the output line buffer.

## Interface
- CPF, 4, activations per beat
- NCH, 2, output channels (≥1)
- DIN_DW, 8, signed activation width
- WW, 8, signed weight width
- BIAS_DW, 16, signed bias width
- ACC_WIDTH, 32, signed accumulator width
- BIAS_SHL, 4, left shift applied to bias before the add
- OUT_SHR, 4, arithmetic right shift with rounding (0 = none)
- DOUT_DW, 8, signed output width
- CW, max(1,$clog2(NCH)), width of `out_ch`
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&in_ready
- in_last  in  1  final beat of vector
- in_data  in  DIN_DW*CPF  activations, lane i at [DIN_DW*(i+1)-1:DIN_DW*i]
- in_weight  in  WW*CPF*NCH  channel c, lane i at index c*CPF+i
- in_bias  in  BIAS_DW*NCH  per-channel bias, sampled only on an accepted last beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  DOUT_DW  result
- out_ch  out  CW  channel index of out_data
- out_last  out  1  high with channel NCH-1

## Operation
- Pipeline: P1 registers CPF×NCH signed products; P2 registers the per-channel sum (sign-extended to ACC_WIDTH); P3 updates the accumulator. A `first` flag travels with each beat; on a first beat the accumulator loads the sum, otherwise it adds the sum. Overflow wraps mod 2^ACC_WIDTH.
- The `first` flag is set on the beat after reset and on the beat after any accepted last beat.
- Input FSM:
  - ACC: in_ready=1.
  - An accepted last beat moves the FSM to FLUSH with in_ready=0. Bias is latched.
  - FLUSH counts 3 cycles, then enters LOAD.
  - LOAD moves the results into the output bank when the bank is empty, or when out_valid&out_ready&out_last in that cycle. Otherwise LOAD holds. On a successful load the FSM returns to ACC.
- Post-process at bank load, per channel:
  - v = acc + (sext(bias) <<< BIAS_SHL)
  - r = (v + 2^(OUT_SHR-1)) >>>OUT_SHR, computed in ACC_WIDTH+2 bits
  - Saturate r to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1]
- Output: the bank holds NCH results. A channel counter starts at 0 and advances on out_valid&out_ready. out_valid drops after channel NCH-1 is popped, unless a load happens in the same cycle.
- in_valid without in_ready is ignored. Beats may have arbitrary gaps. A single-beat vector (first and last on the same beat) is legal.

## Timing
- Reset values: in_ready=0 while rst is high, 1 on the first cycle after; out_valid=0, out_data=0, out_ch=0, out_last=0. The accumulator, pipeline and bank are cleared and the FSM goes to ACC.
- Reset mid-vector or mid-drain discards all partial and pending results. No output follows.
- Latency: a last beat accepted at edge k, with the bank free, produces out_valid high after edge k+4 with channel 0. in_ready returns high after edge k+4.
- Throughput: one beat per cycle within a vector. The minimum gap between vectors is 4 cycles of in_ready low, plus any stall while the bank drains.
- Outputs are held stable while out_valid&!out_ready.
- Loading the bank in the same cycle that the final channel pops is lossless: the next cycle shows channel 0 of the new vector.

## Configuration
- VECTOR_MACN_RELU_EN:
  - Defined: any negative saturated result is forced to 0 before the bank.
  - Undefined: signed results pass through unchanged.

## Test plan
Defaults for all scenarios: CPF=4, NCH=2, shifts 4/4.
- Single beat, in_data all 16, ch0 weights all 1, ch1 weights all -1, bias {ch1=0, ch0=2} -> out 6 (ch0), then -4 (ch1, out_last), first out_valid 4 cycles after the beat. With RELU_EN, ch1 = 0.
- Saturation: in_data all 127, ch0 weights 127, ch1 weights -128, bias 0 -> outputs 127 and -128.
- 3-beat vector with in_valid gaps, in_data beats all 1/2/3, weights all 1 -> acc ch0 = 24, r = (24+8)>>4 = 2. A following single-beat vector confirms the accumulator restarts.
- Backpressure: hold out_ready=0 for 10 cycles while a second vector completes. in_ready stays 0 in LOAD. Releasing out_ready yields the 2 results of vector A then the 2 of vector B back-to-back, with no loss or duplication.
- Assert rst for 1 cycle between ch0 and ch1 of a drain -> out_valid=0, no further outputs, in_ready=1 on the next cycle. The next vector produces correct results.

Source files
------------

// File: rtl/vector_macn_if.sv
// Handshake bundle for vector_macn: beat input (activations, weights, bias)
// and the serialised per-channel result output.
// "slave" is the MAC side; "master" is the fetch/line-buffer side.
interface vector_macn_if #(
    parameter int CPF     = 4,
    parameter int NCH     = 2,
    parameter int DIN_DW  = 8,
    parameter int WW      = 8,
    parameter int BIAS_DW = 16,
    parameter int DOUT_DW = 8,
    parameter int CW      = (NCH > 1) ? $clog2(NCH) : 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [DIN_DW*CPF-1:0]    in_data;
    logic [WW*CPF*NCH-1:0]    in_weight;
    logic [BIAS_DW*NCH-1:0]   in_bias;
    logic                     out_valid;
    logic                     out_ready;
    logic [DOUT_DW-1:0]       out_data;
    logic [CW-1:0]            out_ch;
    logic                     out_last;

    modport slave (
        input  in_valid, in_last, in_data, in_weight, in_bias, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

    modport master (
        output in_valid, in_last, in_data, in_weight, in_bias, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/vector_macn.sv
// Multi-channel vector multiply-accumulate. CPF shared activations per beat,
// NCH channels with private weights; per-channel accumulate over a vector
// ended by in_last, bias add, round/shift, saturate, then serialise one
// channel per cycle on a valid/ready output.
// Optional macro VECTOR_MACN_RELU_EN clamps negative results to zero.
module vector_macn #(
    parameter int CPF       = 4,
    parameter int NCH       = 2,
    parameter int DIN_DW    = 8,
    parameter int WW        = 8,
    parameter int BIAS_DW   = 16,
    parameter int ACC_WIDTH = 32,
    parameter int BIAS_SHL  = 4,
    parameter int OUT_SHR   = 4,
    parameter int DOUT_DW   = 8,
    parameter int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    vector_macn_if.slave  bus
);
    localparam int PW     = DIN_DW + WW;
    localparam int W2     = ACC_WIDTH + 2;
    localparam int RND_SH = (OUT_SHR > 0) ? OUT_SHR - 1 : 0;
    localparam logic signed [W2-1:0] RND  = (OUT_SHR > 0) ? (W2'(1) <<< RND_SH) : '0;
    localparam logic signed [W2-1:0] SMAX = W2'((64'sd1 <<< (DOUT_DW - 1)) - 64'sd1);
    localparam logic signed [W2-1:0] SMIN = W2'(-(64'sd1 <<< (DOUT_DW - 1)));

    typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_LOAD} state_t;

    state_t                      state_q;
    logic [1:0]                  flush_cnt_q;
    logic                        in_ready_q;
    logic                        first_q;
    logic [BIAS_DW*NCH-1:0]      bias_q;

    logic signed [PW-1:0]        prod_q [NCH*CPF];
    logic                        p1_vld_q, p1_first_q;
    logic signed [ACC_WIDTH-1:0] sum_d  [NCH];
    logic signed [ACC_WIDTH-1:0] sum_q  [NCH];
    logic                        p2_vld_q, p2_first_q;
    logic signed [ACC_WIDTH-1:0] acc_q  [NCH];

    logic signed [W2-1:0]        v_d    [NCH];
    logic signed [W2-1:0]        r_d    [NCH];
    logic signed [DOUT_DW-1:0]   res_d  [NCH];
    logic signed [DOUT_DW-1:0]   bank_q [NCH];
    logic                        out_valid_q;
    logic [CW-1:0]               ch_q;

    logic accept, pop, pop_last, load;

    assign bus.in_ready  = in_ready_q & ~rst;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_data  = bank_q[ch_q];
    assign bus.out_last  = out_valid_q & (ch_q == CW'(NCH - 1));
    assign pop           = out_valid_q & bus.out_ready;
    assign pop_last      = pop & bus.out_last;
    // The bank may refill in the very cycle its final channel is popped.
    assign load          = (state_q == ST_LOAD) & (~out_valid_q | pop_last);

    // Input control FSM: accept beats, flush the pipeline, hand off to the bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            flush_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            first_q     <= 1'b1;
            bias_q      <= '0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        first_q <= bus.in_last;
                        if (bus.in_last) begin
                            state_q     <= ST_FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= '0;
                            bias_q      <= bus.in_bias;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 2'd2) begin
                        state_q <= ST_LOAD;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 2'd1;
                    end
                end
                ST_LOAD: begin
                    if (load) begin
                        state_q    <= ST_ACC;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_ACC;
            endcase
        end
    end

    // P1: register every activation x weight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_vld_q   <= 1'b0;
            p1_first_q <= 1'b0;
            for (int unsigned k = 0; k < NCH * CPF; k++) prod_q[k] <= '0;
        end else begin
            p1_vld_q   <= accept;
            p1_first_q <= first_q;
            if (accept) begin
                for (int unsigned k = 0; k < NCH * CPF; k++) begin
                    prod_q[k] <= PW'($signed(bus.in_data[DIN_DW*(k % CPF) +: DIN_DW]))
                               * PW'($signed(bus.in_weight[WW*k +: WW]));
                end
            end
        end
    end

    // Per-channel sum of the CPF products, sign-extended to accumulator width.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            sum_d[c] = '0;
            for (int unsigned i = 0; i < CPF; i++) begin
                sum_d[c] = sum_d[c] + ACC_WIDTH'(prod_q[c*CPF + i]);
            end
        end
    end

    // P2: register the per-channel sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_vld_q   <= 1'b0;
            p2_first_q <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) sum_q[c] <= '0;
        end else begin
            p2_vld_q   <= p1_vld_q;
            p2_first_q <= p1_first_q;
            for (int unsigned c = 0; c < NCH; c++) sum_q[c] <= sum_d[c];
        end
    end

    // P3: accumulate; the first beat of a vector loads instead of adding.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCH; c++) acc_q[c] <= '0;
        end else if (p2_vld_q) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                acc_q[c] <= p2_first_q ? sum_q[c] : acc_q[c] + sum_q[c];
            end
        end
    end

    // Bias add, rounding shift and saturation of each channel's accumulator.
    always_comb begin
        for (int unsigned c = 0; c < NCH; c++) begin
            v_d[c] = W2'(acc_q[c])
                   + (W2'($signed(bias_q[c*BIAS_DW +: BIAS_DW])) <<< BIAS_SHL);
            r_d[c] = (v_d[c] + RND) >>> OUT_SHR;
            if (r_d[c] > SMAX) begin
                res_d[c] = SMAX[DOUT_DW-1:0];
            end else if (r_d[c] < SMIN) begin
                res_d[c] = SMIN[DOUT_DW-1:0];
            end else begin
                res_d[c] = r_d[c][DOUT_DW-1:0];
            end
`ifdef VECTOR_MACN_RELU_EN
            if (res_d[c] < 0) res_d[c] = '0;
`endif
        end
    end

    // Output bank: load finished results, then pop one channel per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ch_q        <= '0;
            for (int unsigned c = 0; c < NCH; c++) bank_q[c] <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            ch_q        <= '0;
            for (int unsigned c = 0; c < NCH; c++) bank_q[c] <= res_d[c];
        end else if (pop) begin
            if (pop_last) begin
                out_valid_q <= 1'b0;
                ch_q        <= '0;
            end else begin
                ch_q <= ch_q + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_vector_macn.sv
// Directed scoreboard bench for vector_macn (CPF=4, NCH=2, shifts 4/4).
`timescale 1ns/1ps
module tb_vector_macn;
    localparam int CPF = 4, NCH = 2, DIN_DW = 8, WW = 8, BIAS_DW = 16, DOUT_DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_macn_if #(.CPF(CPF), .NCH(NCH), .DIN_DW(DIN_DW), .WW(WW),
                     .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW)) bus ();

    vector_macn #(.CPF(CPF), .NCH(NCH), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW),
                  .ACC_WIDTH(32), .BIAS_SHL(4), .OUT_SHR(4), .DOUT_DW(DOUT_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       ch;
        logic       last;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;
    longint acc_m [NCH];
    bit     tb_first = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] post(input longint acc, input int bias);
        longint v, r;
        v = acc + longint'(bias) * 16;
        r = (v + 8) >>> 4;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
`ifdef VECTOR_MACN_RELU_EN
        if (r < 0) r = 0;
`endif
        return r[7:0];
    endfunction

    // Drive one beat, update the reference accumulators, wait for acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [63:0] w,
                             input logic last, input logic [31:0] b);
        int n;
        if (tb_first) for (int c = 0; c < NCH; c++) acc_m[c] = 0;
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < CPF; i++)
                acc_m[c] += longint'($signed(d[8*i +: 8])) * longint'($signed(w[8*(c*CPF+i) +: 8]));
        tb_first = last;
        if (last) begin
            for (int c = 0; c < NCH; c++)
                sb.push_back('{data: post(acc_m[c], $signed(b[16*c +: 16])),
                               ch: c[0], last: (c == NCH - 1)});
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_weight = w;
        bus.in_last   = last;
        bus.in_bias   = last ? b : 32'hdead_beef;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.in_ready !== 1'b1 && n < 50);
        chk("beat_accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = $urandom;
        bus.in_bias  = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compare the shown result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("out_unexpected", sb.size(), 1);
            end else begin
                chk("out_data", bus.out_data, sb[0].data);
                chk("out_ch",   bus.out_ch,   sb[0].ch);
                chk("out_last", bus.out_last, sb[0].last);
                if (bus.out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] rd;
        logic [63:0] rw;
        logic [31:0] rb;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
        bus.in_weight = '0; bus.in_bias = '0; bus.out_ready = 1'b1;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_out_data", bus.out_data, 0);
        chk("post_rst_out_ch", bus.out_ch, 0);
        chk("post_rst_out_last", bus.out_last, 0);
        @(posedge clk); #1;

        // Single beat, bias, latency
        send_beat({4{8'd16}}, {{4{8'hFF}}, {4{8'h01}}}, 1'b1, {16'd0, 16'd2});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_valid_low", bus.out_valid, 0);
            chk("lat_ready_low", bus.in_ready, 0);
        end
        @(negedge clk);
        chk("lat_valid_high", bus.out_valid, 1);
        chk("lat_ready_high", bus.in_ready, 1);
        chk("lat_ch0", bus.out_ch, 0);
        wait_drain();

        // Saturation both ways
        send_beat({4{8'd127}}, {{4{8'h80}}, {4{8'h7F}}}, 1'b1, 32'd0);
        wait_drain();

        // Three-beat vector with gaps, then a restart
        send_beat({4{8'd1}}, {8{8'd1}}, 1'b0, 32'd0);
        repeat (2) @(posedge clk); #1;
        send_beat({4{8'd2}}, {8{8'd1}}, 1'b0, 32'd0);
        repeat (3) @(posedge clk); #1;
        send_beat({4{8'd3}}, {8{8'd1}}, 1'b1, 32'd0);
        send_beat({4{8'd5}}, {8{8'd1}}, 1'b1, 32'd0);
        wait_drain();

        // Backpressure: A sits in the bank while B completes and waits in LOAD
        bus.out_ready = 1'b0;
        send_beat({4{8'd32}}, {{4{8'hFD}}, {4{8'h02}}}, 1'b1, {16'hFFF0, 16'd5});
        send_beat({4{8'd10}}, {8{8'd1}}, 1'b0, 32'd0);
        send_beat({4{8'hF6}}, {{4{8'd3}}, {4{8'hFE}}}, 1'b1, {16'd3, 16'hFFFF});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", bus.in_ready, 0);
            chk("bp_out_valid_held", bus.out_valid, 1);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_back_to_back", bus.out_valid, 1);
        end
        @(negedge clk);
        chk("bp_drained", bus.out_valid, 0);
        wait_drain();

        // Reset between ch0 and ch1 of a drain
        bus.out_ready = 1'b0;
        send_beat({4{8'd20}}, {8{8'd2}}, 1'b1, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.out_valid !== 1'b1 && n < 20);
        chk("rst_drain_valid", bus.out_valid, 1);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        tb_first = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("after_rst_valid", bus.out_valid, 0);
        chk("after_rst_in_ready", bus.in_ready, 1);
        chk("after_rst_ch", bus.out_ch, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("after_rst_quiet", bus.out_valid, 0);
        end
        @(posedge clk); #1;

        // Reset mid-vector discards the partial accumulation
        send_beat({4{8'd100}}, {8{8'd50}}, 1'b0, 32'd0);
        rst = 1'b1;
        tb_first = 1'b1;
        @(posedge clk); #1 rst = 1'b0;

        // Pseudo-random three-beat vector
        for (int b = 0; b < 3; b++) begin
            rd = $urandom;
            rw = {$urandom, $urandom} & 64'h0707_0707_0707_0707;
            rb = {16'hFFC0, 16'($urandom_range(0, 255))};
            send_beat(rd, rw, (b == 2), rb);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
